// File: rtl/spi_serf_pkg.sv
// -----------------------------------------------------------------------------
// spi_pkg
//   Shared definitions for the SPI serf and its monarch.
//   - SPI_WIDTH    : frame length in bits, common to both ends of the link.
//   - serf_state_t : serf FSM state type, with IDLE / ACTIVE constants.
//   - spi_cnt_w()  : width of a counter that must hold 0..width+1.
// -----------------------------------------------------------------------------
package spi_pkg;

  localparam int SPI_WIDTH = 16;

  typedef logic [0:0] serf_state_t;

  localparam serf_state_t IDLE   = 1'b0;
  localparam serf_state_t ACTIVE = 1'b1;

  // The rise counter must reach width+1, because it saturates one past a full frame.
  function automatic int spi_cnt_w(input int width);
    return $clog2(width) + 1;
  endfunction

endpackage

// File: rtl/spi_serf_if.sv
// -----------------------------------------------------------------------------
// spi_serf_if
//   Monarch-driven SPI wires shared by the monarch and the serf.
//   Signals:
//     SS_n  serf select, active-low
//     SCLK  serial clock, idles high (CPOL=1)
//     MOSI  monarch-to-serf data
//   Modports:
//     master : drives SS_n / SCLK / MOSI
//     slave  : observes SS_n / SCLK / MOSI
//   MISO is tri-stated by the serf, so it is a plain port on the serf.
//   Keeping it outside the interface keeps the high-Z driver on an
//   ordinary module port.
// -----------------------------------------------------------------------------
interface spi_serf_if;

  logic SS_n;
  logic SCLK;
  logic MOSI;

  modport master (
    output SS_n,
    output SCLK,
    output MOSI
  );

  modport slave (
    input SS_n,
    input SCLK,
    input MOSI
  );

endinterface

// File: rtl/spi_serf_sync_edge.sv
// -----------------------------------------------------------------------------
// spi_sync_edge
//   N-stage synchronizer for an asynchronous input, plus rise/fall detection.
//   Parameters:
//     STAGES  : number of metastability flops (2 or 3)
//     RST_VAL : reset value of every flop. With the idle level as the reset
//               value, no edge is reported out of reset.
//   Ports:
//     clk, rst_n : system clock; asynchronous active-low reset
//     din        : asynchronous input
//     dout       : synchronized level
//     rise, fall : single-cycle pulses on a synchronized 0->1 / 1->0 change
// -----------------------------------------------------------------------------
module spi_sync_edge #(
  parameter int   STAGES  = 2,
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic dout,
  output logic rise,
  output logic fall
);

  logic [STAGES-1:0] chain;
  logic              prev;

  // Shift the input through the synchronizer. One extra flop holds the
  // previous synchronized level for edge detection.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      chain <= {STAGES{RST_VAL}};
      prev  <= RST_VAL;
    end else begin
      chain <= {chain[STAGES-2:0], din};
      prev  <= chain[STAGES-1];
    end
  end

  assign dout = chain[STAGES-1];
  assign rise = dout & ~prev;
  assign fall = ~dout & prev;

endmodule

// File: rtl/spi_serf.sv
// -----------------------------------------------------------------------------
// spi_serf
//   SPI responder for the team's SPI monarch. It uses CPOL=1/CPHA=1 with
//   WIDTH-bit full-duplex frames. SS_n, SCLK and MOSI are oversampled in the
//   clk domain. The block returns tx_data on MISO and captures MOSI into
//   rx_data. rdy flags a completed frame.
//
//   Parameters:
//     WIDTH       : frame length (must match the monarch, 16)
//     SYNC_STAGES : synchronizer depth on SS_n/SCLK/MOSI (2 or 3)
//
//   Ports:
//     clk      in   system clock (SCLK <= clk/8)
//     rst_n    in   asynchronous active-low reset
//     spi      in   spi_serf_if.slave: SS_n, SCLK, MOSI
//     MISO     out  serf-to-monarch data, high-Z while raw SS_n is high
//     tx_data  in   response word, sampled at frame start
//     clr_rdy  in   single-cycle clear of rdy (and of frm_err)
//     rx_data  out  last complete received word
//     rdy      out  level, set one clk after a valid frame ends
//     frm_err  out  sticky short/long-frame flag
//
//   Build option:
//     SPI_SERF_FRM_ERR_EN : when defined, a frame that ends with the wrong
//                           number of SCLK rises sets frm_err.
//                           Otherwise frm_err is tied to 0 and bad frames
//                           are dropped silently.
// -----------------------------------------------------------------------------
module spi_serf
  import spi_pkg::*;
#(
  parameter int WIDTH       = SPI_WIDTH,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  spi_serf_if.slave        spi,
  output logic             MISO,
  input  logic [WIDTH-1:0] tx_data,
  input  logic             clr_rdy,
  output logic [WIDTH-1:0] rx_data,
  output logic             rdy,
  output logic             frm_err
);

  localparam int                CNT_W    = spi_cnt_w(WIDTH);
  localparam logic [CNT_W-1:0]  CNT_FULL = CNT_W'(WIDTH);
  localparam logic [CNT_W-1:0]  CNT_SAT  = CNT_W'(WIDTH + 1);
  localparam logic [2:0]        FLUSH    = 3'(SYNC_STAGES + 1);

  logic ss_sync, ss_rise, ss_fall;
  logic sclk_sync, sclk_rise, sclk_fall;
  logic mosi_sync;
  logic [SYNC_STAGES-1:0] mosi_chain;

  serf_state_t      state;
  logic [WIDTH-1:0] shft;
  logic [WIDTH-1:0] shft_next;
  logic [CNT_W-1:0] rise_cnt;
  logic             mosi_smpl;
  logic             rdy_set;
  logic             frame_start;
  logic [2:0]       flush_cnt;
  logic             armed;

  spi_sync_edge #(
    .STAGES  (SYNC_STAGES),
    .RST_VAL (1'b1)
  ) u_ss_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .din   (spi.SS_n),
    .dout  (ss_sync),
    .rise  (ss_rise),
    .fall  (ss_fall)
  );

  spi_sync_edge #(
    .STAGES  (SYNC_STAGES),
    .RST_VAL (1'b1)
  ) u_sclk_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .din   (spi.SCLK),
    .dout  (sclk_sync),
    .rise  (sclk_rise),
    .fall  (sclk_fall)
  );

  // MOSI only needs a synchronized level. The data is sampled on the
  // synchronized SCLK rise, so it has the same latency as the clock.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mosi_chain <= '1;
    end else begin
      mosi_chain <= {mosi_chain[SYNC_STAGES-2:0], spi.MOSI};
    end
  end

  assign mosi_sync = mosi_chain[SYNC_STAGES-1];

  // Because the synchronizers reset to 1, SS_n held low across reset release
  // looks like a fresh falling edge. The serf is armed only after the
  // synchronizers have flushed and both SS_n and SCLK are seen idle high.
  // This makes a frame already in progress at release get ignored.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flush_cnt <= 3'd0;
      armed     <= 1'b0;
    end else begin
      if (flush_cnt != FLUSH) begin
        flush_cnt <= flush_cnt + 3'd1;
      end
      if (flush_cnt == FLUSH && ss_sync && sclk_sync) begin
        armed <= 1'b1;
      end
    end
  end

  assign frame_start = (state == IDLE) && ss_fall && armed;
  assign shft_next   = {shft[WIDTH-2:0], mosi_smpl};

  // Frame FSM. The leading SCLK fall of a frame arrives before any rise and
  // is skipped, so the MSB stays on MISO for the first sample. The last shift
  // happens on SS_n rise, because the monarch produces no trailing fall.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      shft      <= '0;
      rise_cnt  <= '0;
      mosi_smpl <= 1'b0;
      rx_data   <= '0;
      rdy_set   <= 1'b0;
    end else begin
      rdy_set <= 1'b0;
      if (state == IDLE) begin
        if (frame_start) begin
          shft     <= tx_data;
          rise_cnt <= '0;
          state    <= ACTIVE;
        end
      end else begin
        if (ss_rise) begin
          state <= IDLE;
          if (rise_cnt == CNT_FULL) begin
            shft    <= shft_next;
            rx_data <= shft_next;
            rdy_set <= 1'b1;
          end
        end else begin
          if (sclk_rise) begin
            mosi_smpl <= mosi_sync;
            if (rise_cnt != CNT_SAT) begin
              rise_cnt <= rise_cnt + 1'b1;
            end
          end
          if (sclk_fall && rise_cnt != '0 && rise_cnt <= CNT_FULL) begin
            shft <= shft_next;
          end
        end
      end
    end
  end

  // rdy goes high one clk after a good frame ends. A clear from clr_rdy or
  // from the next frame start takes priority over a simultaneous set.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdy <= 1'b0;
    end else if (clr_rdy || frame_start) begin
      rdy <= 1'b0;
    end else if (rdy_set) begin
      rdy <= 1'b1;
    end
  end

`ifdef SPI_SERF_FRM_ERR_EN
  logic bad_end;

  assign bad_end = (state == ACTIVE) && ss_rise && (rise_cnt != CNT_FULL);

  // A frame that ends with the wrong rise count sets a sticky error flag.
  // clr_rdy or the next frame start clears it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frm_err <= 1'b0;
    end else if (clr_rdy || frame_start) begin
      frm_err <= 1'b0;
    end else if (bad_end) begin
      frm_err <= 1'b1;
    end
  end
`else
  assign frm_err = 1'b0;
`endif

  // MISO follows the raw select so the line is released immediately when
  // SS_n goes high.
  assign MISO = spi.SS_n ? 1'bz : shft[WIDTH-1];

endmodule

// File: tb/tb_spi_serf.sv
// -----------------------------------------------------------------------------
// tb_spi_serf
//   Bench for spi_serf. A CPOL=1/CPHA=1 monarch runs SCLK at clk/16.
//   A frame-level model tracks the expected rx_data / rdy / frm_err.
//   A compare process checks the DUT against that model on every clk in
//   which the outputs have settled since the last SS_n / clr_rdy / reset
//   event. It also checks that MISO is high-Z whenever SS_n is high.
//   The directed tests also carry hand-computed literal expectations.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_spi_serf;
  import spi_pkg::*;

  localparam int W      = SPI_WIDTH;
  localparam int STAGES = 2;
  localparam int HALF   = 8;
  localparam int CLK_P  = 10;
  localparam int QUIET  = STAGES + 4;
  localparam int GAP    = 12;
`ifdef SPI_SERF_FRM_ERR_EN
  localparam logic ERR_EN = 1'b1;
`else
  localparam logic ERR_EN = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst_n;
  logic [W-1:0] tx_data;
  logic         clr_rdy;
  wire          miso;
  logic [W-1:0] rx_data;
  logic         rdy;
  logic         frm_err;
  logic         miso_z;

  logic [W-1:0] model_rx;
  logic         model_rdy;
  logic         model_err;
  time          last_evt;

  int checks = 0;
  int errors = 0;

  spi_serf_if spi_if ();

  spi_serf #(
    .WIDTH       (W),
    .SYNC_STAGES (STAGES)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .spi     (spi_if),
    .MISO    (miso),
    .tx_data (tx_data),
    .clr_rdy (clr_rdy),
    .rx_data (rx_data),
    .rdy     (rdy),
    .frm_err (frm_err)
  );

  always #(CLK_P/2) clk = ~clk;

  assign miso_z = (miso === 1'bz);

  // Compare one value against its expectation, count it, and report a failure.
  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: actual %0h required %0h", name, act, exp);
    end
  endtask

  task automatic waitClk(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Per-cycle check against the frame-level model.
  always @(negedge clk) begin
    if (spi_if.SS_n === 1'b1) begin
      checkOutput("miso_hiz", {31'd0, miso_z}, 32'd1);
    end
    if (($time - last_evt) >= QUIET * CLK_P) begin
      checkOutput("model_rx_data", {16'd0, rx_data}, {16'd0, model_rx});
      checkOutput("model_rdy", {31'd0, rdy}, {31'd0, model_rdy});
      checkOutput("model_frm_err", {31'd0, frm_err}, {31'd0, model_err});
    end
  end

  // Monarch side of one frame, up to (not including) SS_n rising.
  // MOSI changes on each SCLK fall. MISO is sampled on each SCLK rise.
  task automatic applyStimulus(input logic [W-1:0] word, input logic [W-1:0] resp,
                               input int n_rises, output logic [W-1:0] rd);
    tx_data     = resp;
    rd          = '0;
    spi_if.SS_n = 1'b0;
    last_evt    = $time;
    model_rdy   = 1'b0;
    model_err   = 1'b0;
    waitClk(HALF);
    @(negedge clk);
    checkOutput("rdy_after_ss_fall", {31'd0, rdy}, 32'd0);
    for (int k = 0; k < n_rises; k++) begin
      spi_if.SCLK = 1'b0;
      spi_if.MOSI = word[W-1-k];
      waitClk(HALF);
      spi_if.SCLK = 1'b1;
      rd          = {rd[W-2:0], miso};
      waitClk(HALF);
    end
  endtask

  // Raise SS_n and update the model from the frame-completion rules.
  task automatic ssRelease(input logic [W-1:0] word, input int n_rises, input logic accepted);
    spi_if.SS_n = 1'b1;
    last_evt    = $time;
    if (accepted) begin
      if (n_rises == W) begin
        model_rx  = word;
        model_rdy = 1'b1;
      end else begin
        model_err = ERR_EN;
      end
    end
  endtask

  // Wait a bounded number of clks for rdy to rise, and return the latency.
  task automatic waitRdy(output int n);
    n = 0;
    for (int i = 1; i <= STAGES + 3 && n == 0; i++) begin
      @(posedge clk);
      @(negedge clk);
      if (rdy === 1'b1) n = i;
    end
    checks++;
    if (n == 0) begin
      errors++;
      $display("[TB] FAIL rdy_latency: rdy=%b after %0d clk, required 1", rdy, STAGES + 3);
    end
  endtask

  logic [W-1:0] rd1, rd2;
  int           n_rdy;

  initial begin
    spi_if.SS_n = 1'b1;
    spi_if.SCLK = 1'b1;
    spi_if.MOSI = 1'b0;
    tx_data     = '0;
    clr_rdy     = 1'b0;
    model_rx    = '0;
    model_rdy   = 1'b0;
    model_err   = 1'b0;
    last_evt    = 0;
    rst_n       = 1'b0;
    n_rdy       = 0;
    waitClk(3);
    rst_n = 1'b1;
    waitClk(10);

    // Reset state.
    @(negedge clk);
    checkOutput("reset_rdy", {31'd0, rdy}, 32'd0);
    checkOutput("reset_rx_data", {16'd0, rx_data}, 32'd0);
    checkOutput("reset_frm_err", {31'd0, frm_err}, 32'd0);

    // SCLK/MOSI activity with SS_n high is ignored.
    for (int k = 0; k < 4; k++) begin
      spi_if.SCLK = 1'b0;
      spi_if.MOSI = ~spi_if.MOSI;
      waitClk(4);
      spi_if.SCLK = 1'b1;
      waitClk(4);
    end
    @(negedge clk);
    checkOutput("idle_rdy", {31'd0, rdy}, 32'd0);
    checkOutput("idle_rx_data", {16'd0, rx_data}, 32'd0);
    checkOutput("idle_miso_z", {31'd0, miso_z}, 32'd1);

    // Basic frame: A5C3 in, 3C5A out.
    applyStimulus(16'hA5C3, 16'h3C5A, W, rd1);
    ssRelease(16'hA5C3, W, 1'b1);
    waitRdy(n_rdy);
    checkOutput("basic_rx_data", {16'd0, rx_data}, 32'h0000A5C3);
    checkOutput("basic_monarch_rd", {16'd0, rd1}, 32'h00003C5A);
    checkOutput("basic_miso_z_after", {31'd0, miso_z}, 32'd1);
    waitClk(GAP);

    // clr_rdy while rdy is high clears it on the next clk and holds rx_data.
    clr_rdy   = 1'b1;
    model_rdy = 1'b0;
    last_evt  = $time;
    waitClk(1);
    clr_rdy = 1'b0;
    @(negedge clk);
    checkOutput("clr_rdy_next_clk", {31'd0, rdy}, 32'd0);
    checkOutput("clr_rdy_rx_held", {16'd0, rx_data}, 32'h0000A5C3);
    waitClk(GAP);

    // Back-to-back frames with the minimum SS_n-high gap.
    applyStimulus(16'h0001, 16'hFFFF, W, rd1);
    ssRelease(16'h0001, W, 1'b1);
    waitClk(STAGES + 3);
    @(negedge clk);
    checkOutput("b2b_rdy_before_fall", {31'd0, rdy}, 32'd1);
    checkOutput("b2b_rx_first", {16'd0, rx_data}, 32'h00000001);
    applyStimulus(16'h8000, 16'h0000, W, rd2);
    ssRelease(16'h8000, W, 1'b1);
    waitRdy(n_rdy);
    checkOutput("b2b_rx_data", {16'd0, rx_data}, 32'h00008000);
    checkOutput("b2b_monarch_rd1", {16'd0, rd1}, 32'h0000FFFF);
    checkOutput("b2b_monarch_rd2", {16'd0, rd2}, 32'h00000000);
    waitClk(GAP);

    // clr_rdy in the same clk as the set: the clear wins.
    applyStimulus(16'h5A5A, 16'h1111, W, rd1);
    ssRelease(16'h5A5A, W, 1'b1);
    if (n_rdy > 1) waitClk(n_rdy - 1);
    clr_rdy   = 1'b1;
    model_rdy = 1'b0;
    last_evt  = $time;
    waitClk(1);
    clr_rdy = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checkOutput("clr_same_cycle_rdy", {31'd0, rdy}, 32'd0);
    end
    checkOutput("clr_same_cycle_rx", {16'd0, rx_data}, 32'h00005A5A);
    checkOutput("clr_same_cycle_rd", {16'd0, rd1}, 32'h00001111);
    waitClk(GAP);

    // Short frame: SS_n rises after 8 SCLK rises.
    applyStimulus(16'hFF00, 16'h0000, 8, rd1);
    ssRelease(16'hFF00, 8, 1'b1);
    waitClk(GAP);
    @(negedge clk);
    checkOutput("short_frm_err", {31'd0, frm_err}, {31'd0, ERR_EN});
    checkOutput("short_rdy", {31'd0, rdy}, 32'd0);
    checkOutput("short_rx_held", {16'd0, rx_data}, 32'h00005A5A);
    applyStimulus(16'h1234, 16'h0000, W, rd1);
    ssRelease(16'h1234, W, 1'b1);
    waitRdy(n_rdy);
    checkOutput("after_short_frm_err", {31'd0, frm_err}, 32'd0);
    checkOutput("after_short_rx", {16'd0, rx_data}, 32'h00001234);
    waitClk(GAP);

    // Reset after 5 rises of a BEEF frame, released while SS_n is still low.
    applyStimulus(16'hBEEF, 16'h0F0F, 5, rd1);
    rst_n     = 1'b0;
    model_rx  = '0;
    model_rdy = 1'b0;
    model_err = 1'b0;
    last_evt  = $time;
    waitClk(3);
    @(negedge clk);
    checkOutput("mid_rst_rdy", {31'd0, rdy}, 32'd0);
    checkOutput("mid_rst_rx", {16'd0, rx_data}, 32'd0);
    rst_n    = 1'b1;
    last_evt = $time;
    for (int k = 5; k < W; k++) begin
      spi_if.SCLK = 1'b0;
      spi_if.MOSI = ~spi_if.MOSI;
      waitClk(HALF);
      spi_if.SCLK = 1'b1;
      waitClk(HALF);
    end
    ssRelease(16'hBEEF, W, 1'b0);
    waitClk(GAP);
    @(negedge clk);
    checkOutput("ignored_frame_rdy", {31'd0, rdy}, 32'd0);
    checkOutput("ignored_frame_rx", {16'd0, rx_data}, 32'd0);
    checkOutput("ignored_frame_err", {31'd0, frm_err}, 32'd0);
    applyStimulus(16'hCAFE, 16'h0000, W, rd1);
    ssRelease(16'hCAFE, W, 1'b1);
    waitRdy(n_rdy);
    checkOutput("post_rst_rx", {16'd0, rx_data}, 32'h0000CAFE);
    waitClk(GAP);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
